// File: rtl/fp_pkg.sv
// Shared floating-point datapath definitions.
//   - adjOp_t       : decoded exponent-adjust opcode driven by the normaliser
//   - DEFAULT_EXP_W : default exponent width (all-ones encodes Inf/NaN)
//   - DEFAULT_SHIFT_W : default normalisation shift width (<= exponent width)
//   - EXP_MAX       : all-ones exponent at the default width
package fp_pkg;

  localparam int DEFAULT_EXP_W   = 8;
  localparam int DEFAULT_SHIFT_W = 5;

  localparam logic [DEFAULT_EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic [1:0] {
    OP_SUB  = 2'b00,  // exp - shift (mantissa was left-normalised)
    OP_INC  = 2'b01,  // exp + 1     (mantissa carried out)
    OP_ZERO = 2'b10,  // exact zero result
    OP_PASS = 2'b11   // exponent unchanged
  } adjOp_t;

endpackage

// File: rtl/exp_adjust_core.sv
// Combinational exponent-adjust classifier.
// Takes the stage-1 registers and produces the next result exponent together
// with overflow / underflow classification.
//   exp    : registered larger operand exponent
//   shift  : registered normalisation shift amount
//   op     : registered adjust opcode (adjOp_t encoding)
//   diff   : {1'b0,exp} - zext(shift), MSB set means shift > exp
//   sum    : exp + 1, EXP_W+1 bits
//   adjExp : adjusted exponent
//   adjOf  : overflow (saturated to all-ones)
//   adjUf  : underflow (flushed to zero)
module exp_adjust_core
  import fp_pkg::*;
#(
  parameter int EXP_W   = DEFAULT_EXP_W,
  parameter int SHIFT_W = DEFAULT_SHIFT_W
) (
  input  logic [EXP_W-1:0]   exp,
  input  logic [SHIFT_W-1:0] shift,
  input  logic [1:0]         op,
  input  logic [EXP_W:0]     diff,
  input  logic [EXP_W:0]     sum,
  output logic [EXP_W-1:0]   adjExp,
  output logic               adjOf,
  output logic               adjUf
);

  // An INC result of all-ones would alias Inf/NaN, so exp+1 reaching
  // all-ones is already an overflow.
  localparam logic [EXP_W:0] INC_LIMIT = {1'b0, {EXP_W{1'b1}}};

  adjOp_t opType;
  assign opType = adjOp_t'(op);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    adjExp = exp;
    adjOf  = 1'b0;
    adjUf  = 1'b0;
    case (opType)
      OP_SUB: begin
        if (diff[EXP_W]) begin
          adjExp = '0;
          adjUf  = 1'b1;
        end else if (diff == '0) begin
          // Landing exactly on 0 is a denormal boundary: only a real shift
          // counts as underflow, exp=0/shift=0 is a legitimate zero exponent.
          adjExp = '0;
          adjUf  = (shift != '0);
        end else begin
          adjExp = diff[EXP_W-1:0];
        end
      end
      OP_INC: begin
        if (sum >= INC_LIMIT) begin
          adjExp = '1;
          adjOf  = 1'b1;
        end else begin
          adjExp = sum[EXP_W-1:0];
        end
      end
      OP_ZERO: adjExp = '0;
      default: adjExp = exp;  // OP_PASS
    endcase
  end

endmodule

// File: rtl/exponent_normalizer.sv
// Two-stage valid/ready exponent-adjust stage of the FP adder datapath.
// Stage 1 registers the item and precomputes exp-shift and exp+1; stage 2
// registers the classified result. Sticky flags accumulate exceptions of
// items actually handed to the consumer.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake (in_ready combinational from out_ready)
//   in_exp/in_shift     : larger exponent and normalisation shift
//   in_op/in_tag        : adjust opcode (adjOp_t) and opaque sideband tag
//   out_valid/out_ready : output handshake
//   out_exp/out_of/out_uf/out_tag : registered result of the head item
//   clr_sticky          : clears sticky flags (wins over a same-cycle set)
//   of_sticky/uf_sticky : OR of transferred out_of / out_uf
// SHIFT_W must not exceed EXP_W.
module exponent_normalizer
  import fp_pkg::*;
#(
  parameter int EXP_W   = DEFAULT_EXP_W,
  parameter int SHIFT_W = DEFAULT_SHIFT_W,
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [EXP_W-1:0]   in_exp,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXP_W-1:0]   out_exp,
  output logic               out_of,
  output logic               out_uf,
  output logic [TAG_W-1:0]   out_tag,
  input  logic               clr_sticky,
  output logic               of_sticky,
  output logic               uf_sticky
);

  logic               s1Valid;
  logic [EXP_W-1:0]   s1Exp;
  logic [SHIFT_W-1:0] s1Shift;
  logic [1:0]         s1Op;
  logic [TAG_W-1:0]   s1Tag;
  logic [EXP_W:0]     s1Diff;
  logic [EXP_W:0]     s1Sum;

  logic [EXP_W:0]     diffNext;
  logic [EXP_W:0]     sumNext;

  logic [EXP_W-1:0]   adjExp;
  logic               adjOf;
  logic               adjUf;

  logic               s2Advance;
  logic               s1Advance;
  logic               outXfer;

  // A stage moves whenever its downstream slot is free or being vacated this
  // cycle, so a full pipe streams one item per cycle without a bubble.
  assign s2Advance = !out_valid || out_ready;
  assign s1Advance = !s1Valid || s2Advance;
  assign in_ready  = !reset && s1Advance;
  assign outXfer   = out_valid && out_ready;

  assign diffNext = {1'b0, in_exp} - {{(EXP_W + 1 - SHIFT_W){1'b0}}, in_shift};
  assign sumNext  = {1'b0, in_exp} + {{EXP_W{1'b0}}, 1'b1};

  // Stage 1: capture the item and the two candidate exponents.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      s1Valid <= 1'b0;
      s1Exp   <= '0;
      s1Shift <= '0;
      s1Op    <= '0;
      s1Tag   <= '0;
      s1Diff  <= '0;
      s1Sum   <= '0;
    end else if (s1Advance) begin
      s1Valid <= in_valid;
      if (in_valid) begin
        s1Exp   <= in_exp;
        s1Shift <= in_shift;
        s1Op    <= in_op;
        s1Tag   <= in_tag;
        s1Diff  <= diffNext;
        s1Sum   <= sumNext;
      end
    end
  end

  exp_adjust_core #(
    .EXP_W  (EXP_W),
    .SHIFT_W(SHIFT_W)
  ) u_core (
    .exp   (s1Exp),
    .shift (s1Shift),
    .op    (s1Op),
    .diff  (s1Diff),
    .sum   (s1Sum),
    .adjExp(adjExp),
    .adjOf (adjOf),
    .adjUf (adjUf)
  );

  // Stage 2: output registers. Payload only loads with a real item, so it
  // holds steady during a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_exp   <= '0;
      out_of    <= 1'b0;
      out_uf    <= 1'b0;
      out_tag   <= '0;
    end else if (s2Advance) begin
      out_valid <= s1Valid;
      if (s1Valid) begin
        out_exp <= adjExp;
        out_of  <= adjOf;
        out_uf  <= adjUf;
        out_tag <= s1Tag;
      end
    end
  end

  // Sticky exception flags, accumulated on consumer transfers only.
  always_ff @(posedge clk) begin
    if (reset || clr_sticky) begin
      of_sticky <= 1'b0;
      uf_sticky <= 1'b0;
    end else if (outXfer) begin
      of_sticky <= of_sticky | out_of;
      uf_sticky <= uf_sticky | out_uf;
    end
  end

endmodule

// File: tb/tb_exponent_normalizer.sv
// Self-checking bench for exponent_normalizer: directed corner vectors,
// backpressure, sticky, mid-flight reset and a randomized phase, all scored
// against an integer-arithmetic reference model and an expected-item queue.
module tb_exponent_normalizer;

  localparam int EXP_W   = 8;
  localparam int SHIFT_W = 5;
  localparam int TAG_W   = 4;
  localparam int EXP_ALL = (1 << EXP_W) - 1;

  typedef struct {
    logic [EXP_W-1:0] exp;
    logic             of;
    logic             uf;
    logic [TAG_W-1:0] tag;
  } item_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [EXP_W-1:0]   in_exp = '0;
  logic [SHIFT_W-1:0] in_shift = '0;
  logic [1:0]         in_op = '0;
  logic [TAG_W-1:0]   in_tag = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [EXP_W-1:0]   out_exp;
  logic               out_of;
  logic               out_uf;
  logic [TAG_W-1:0]   out_tag;
  logic               clr_sticky = 1'b0;
  logic               of_sticky;
  logic               uf_sticky;

  exponent_normalizer #(
    .EXP_W(EXP_W), .SHIFT_W(SHIFT_W), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_exp(in_exp), .in_shift(in_shift), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_exp(out_exp), .out_of(out_of), .out_uf(out_uf), .out_tag(out_tag),
    .clr_sticky(clr_sticky), .of_sticky(of_sticky), .uf_sticky(uf_sticky)
  );

  always #5 clk = ~clk;

  int    compCount = 0;
  int    failCount = 0;
  item_t sb[$];
  logic  stOf = 1'b0, stUf = 1'b0;
  logic  stalledPrev = 1'b0;
  item_t saved;
  logic  lastOutValid = 1'b0;
  logic  lastInReady = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compCount++;
    assert (obs === expv) else begin
      failCount++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference model straight from the adjust rules, in plain integers.
  function automatic item_t refModel(input int e, input int s, input int op, input int t);
    item_t r;
    int d;
    r.tag = t[TAG_W-1:0];
    r.of = 1'b0;
    r.uf = 1'b0;
    r.exp = '0;
    case (op)
      0: begin
        d = e - s;
        if (d < 0) r.uf = 1'b1;
        else if (d == 0) r.uf = (s != 0);
        else r.exp = d[EXP_W-1:0];
      end
      1: begin
        if (e + 1 >= EXP_ALL) begin r.exp = EXP_ALL[EXP_W-1:0]; r.of = 1'b1; end
        else r.exp = 8'(e + 1);
      end
      2: r.exp = '0;
      default: r.exp = e[EXP_W-1:0];
    endcase
    return r;
  endfunction

  // One clock: drive at negedge, observe 1 time unit later, score the
  // transfers that the coming posedge will perform.
  task automatic doCycle(input logic v, input int e, input int s, input int o, input int t,
                         input logic oR, input logic clr, output logic acc);
    item_t exp_i;
    logic  xferOut;
    @(negedge clk);
    reset = 1'b0;
    in_valid = v;
    in_exp = e[EXP_W-1:0];
    in_shift = s[SHIFT_W-1:0];
    in_op = o[1:0];
    in_tag = t[TAG_W-1:0];
    out_ready = oR;
    clr_sticky = clr;
    #1;
    check("of_sticky", of_sticky, stOf);
    check("uf_sticky", uf_sticky, stUf);
    check("in_ready", in_ready, !(sb.size() == 2 && !oR));
    if (stalledPrev) begin
      check("stall_exp", out_exp, saved.exp);
      check("stall_of", out_of, saved.of);
      check("stall_uf", out_uf, saved.uf);
      check("stall_tag", out_tag, saved.tag);
    end
    stalledPrev = out_valid && !oR;
    saved.exp = out_exp; saved.of = out_of; saved.uf = out_uf; saved.tag = out_tag;
    lastOutValid = out_valid;
    lastInReady = in_ready;
    acc = v && in_ready;
    xferOut = out_valid && oR;
    if (xferOut) begin
      check("item_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        exp_i = sb.pop_front();
        check("out_exp", out_exp, exp_i.exp);
        check("out_of", out_of, exp_i.of);
        check("out_uf", out_uf, exp_i.uf);
        check("out_tag", out_tag, exp_i.tag);
      end
    end
    if (acc) sb.push_back(refModel(e, s, o, t));
    if (clr) begin stOf = 1'b0; stUf = 1'b0; end
    else if (xferOut) begin stOf = stOf | out_of; stUf = stUf | out_uf; end
  endtask

  task automatic idle(input logic oR, input logic clr);
    logic acc;
    doCycle(1'b0, 0, 0, 0, 0, oR, clr, acc);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    clr_sticky = 1'b0;
    #1;
    check("in_ready_in_reset", in_ready, 1'b0);
    sb.delete();
    stOf = 1'b0; stUf = 1'b0;
    stalledPrev = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_exp", out_exp, 0);
    check("rst_out_of", out_of, 1'b0);
    check("rst_out_uf", out_uf, 1'b0);
    check("rst_out_tag", out_tag, 0);
    check("rst_of_sticky", of_sticky, 1'b0);
    check("rst_uf_sticky", uf_sticky, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && sb.size() != 0; i++) idle(1'b1, 1'b0);
    check("drain_empty", sb.size(), 0);
  endtask

  // Offer one item until accepted, within a cycle budget.
  task automatic send(input int e, input int s, input int o, input int t, input logic oR);
    logic acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) doCycle(1'b1, e, s, o, t, oR, 1'b0, acc);
    check("send_accepted", acc, 1'b1);
  endtask

  initial begin
    logic acc;
    int   idx, cyc;
    logic sawFull;
    int   vecE[10] = '{8'h80, 8'h05, 8'h03, 8'h00, 8'h7F, 8'hFD, 8'hFE, 8'hFF, 8'h42, 8'h42};
    int   vecS[10] = '{5, 5, 7, 0, 0, 0, 0, 0, 3, 3};
    int   vecO[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 3};

    doReset();

    // Latency: one item, out_valid must rise exactly two edges later.
    send(8'h80, 5, 0, 4'hA, 1'b1);
    idle(1'b1, 1'b0);
    check("latency_cycle1", lastOutValid, 1'b0);
    idle(1'b1, 1'b0);
    check("latency_cycle2", lastOutValid, 1'b1);
    drain();

    // Directed corner vectors, back to back.
    for (int i = 0; i < 10; i++) send(vecE[i], vecS[i], vecO[i], i, 1'b1);
    drain();

    // Backpressure: 8 items, consumer stalls cycles 3..7.
    idx = 0; cyc = 0; sawFull = 1'b0;
    while (idx < 8 && cyc < 40) begin
      doCycle(1'b1, $urandom_range(0, 255), $urandom_range(0, 31), $urandom_range(0, 3),
              idx, !(cyc >= 3 && cyc < 8), 1'b0, acc);
      if (!lastInReady) sawFull = 1'b1;
      if (acc) idx++;
      cyc++;
    end
    check("bp_all_sent", idx, 8);
    check("bp_in_ready_low_when_full", sawFull, 1'b1);
    drain();

    // Sticky: underflow only, then overflow transfer masked by clear.
    idle(1'b1, 1'b1);
    send(8'h05, 5, 0, 1, 1'b1);
    drain();
    idle(1'b1, 1'b0);
    #1;
    check("uf_sticky_set", uf_sticky, 1'b1);
    check("of_sticky_clear", of_sticky, 1'b0);
    send(8'hFE, 0, 1, 2, 1'b0);
    for (int i = 0; i < 5 && !lastOutValid; i++) idle(1'b0, 1'b0);
    check("of_item_waiting", lastOutValid, 1'b1);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);
    #1;
    check("clr_wins_of", of_sticky, 1'b0);
    check("clr_wins_uf", uf_sticky, 1'b0);

    // Reset with two items in flight, then full-rate streaming.
    send(8'h10, 1, 0, 3, 1'b0);
    send(8'h20, 2, 0, 4, 1'b0);
    check("two_in_flight", sb.size(), 2);
    doReset();
    for (int i = 0; i < 6; i++) begin
      doCycle(1'b1, $urandom_range(0, 255), $urandom_range(0, 31), $urandom_range(0, 3),
              i, 1'b1, 1'b0, acc);
      check("throughput_accept", acc, 1'b1);
    end
    drain();

    // Randomized traffic with random backpressure and clears.
    for (int i = 0; i < 300; i++) begin
      doCycle($urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 31),
              $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 3) != 0,
              $urandom_range(0, 15) == 0, acc);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
